// File: rtl/skew_rd_sched.sv
// Skewed-read scheduler: one command at a time, per-lane read enables/addresses
// with optional diagonal skew, a latency-matched data_valid pipe and a done pulse.

module skew_rd_lane #(
    parameter int LANE       = 0,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  issue,
    input  logic [CNT_WIDTH-1:0]  t,
    input  logic [CNT_WIDTH-1:0]  n,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic                  aligned,
    output logic                  en,
    output logic [ADDR_WIDTH-1:0] addr
);
    localparam logic [CNT_WIDTH-1:0] OFS = CNT_WIDTH'(LANE);

    logic [CNT_WIDTH-1:0] rel;

    always_comb begin
        rel = aligned ? t : t - OFS;
        if (aligned) en = issue && (t < n);
        else         en = issue && (t >= OFS) && (t < n + OFS);
        addr = en ? base + ADDR_WIDTH'(rel) : '1;
    end
endmodule

module skew_rd_sched #(
    parameter int SYS_ROW    = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int ROW_WIDTH  = 16,
    parameter int MAX_ROW    = 256,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDR_WIDTH-1:0]         cmd_base,
    input  logic [ROW_WIDTH-1:0]          cmd_num_row,
    input  logic                          cmd_aligned,
    output logic [SYS_ROW-1:0]            rd_en,
    output logic [SYS_ROW*ADDR_WIDTH-1:0] rd_addr,
    output logic [SYS_ROW-1:0]            data_valid,
    output logic                          busy,
    output logic                          done
);
    localparam int CNT_WIDTH = $clog2(MAX_ROW + SYS_ROW) + 1;
    localparam int DW        = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                               state_q, state_d;
    logic [CNT_WIDTH-1:0]                 cnt_q, cnt_d;
    logic [DW-1:0]                        dcnt_q, dcnt_d;
    logic [ADDR_WIDTH-1:0]                base_q, base_d;
    logic [CNT_WIDTH-1:0]                 n_q, n_d;
    logic                                 aligned_q, aligned_d;
    logic                                 done_q, done_d;
    logic [SYS_ROW-1:0]                   rd_en_q, rd_en_d;
    logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [RD_LAT-1:0][SYS_ROW-1:0]       vld_pipe_q, vld_pipe_d;

    logic [31:0]                          num_ext;
    logic [CNT_WIDTH-1:0]                 n_in, len_q, t_nxt;
    logic                                 issue_nxt, last;
    logic [SYS_ROW-1:0]                   lane_en;
    logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]   lane_addr;

    always_comb begin
        num_ext = 32'(cmd_num_row);
        n_in    = (num_ext > 32'(MAX_ROW)) ? CNT_WIDTH'(MAX_ROW) : CNT_WIDTH'(num_ext);
        len_q   = aligned_q ? n_q : n_q + CNT_WIDTH'(SYS_ROW - 1);
        last    = (cnt_q == len_q - CNT_WIDTH'(1));
    end

    // Lanes see the index that will be on the outputs next cycle, so rd_en/rd_addr
    // can be registered and still show t=0 in the cycle right after acceptance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        base_d    = base_q;
        n_d       = n_q;
        aligned_d = aligned_q;
        done_d    = 1'b0;
        issue_nxt = 1'b0;
        t_nxt     = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    base_d    = cmd_base;
                    n_d       = n_in;
                    aligned_d = cmd_aligned;
                    if (n_in == '0) begin
                        // Empty command: one busy cycle carrying done, then idle.
                        state_d = DRAIN;
                        dcnt_d  = DW'(RD_LAT - 1);
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        cnt_d     = '0;
                        issue_nxt = 1'b1;
                        t_nxt     = '0;
                    end
                end
            end
            ISSUE: begin
                if (last) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                    done_d  = (RD_LAT == 1);
                end else begin
                    cnt_d     = cnt_q + CNT_WIDTH'(1);
                    issue_nxt = 1'b1;
                    t_nxt     = cnt_q + CNT_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == DW'(RD_LAT - 1)) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                    done_d = (int'(dcnt_q) == RD_LAT - 2);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < SYS_ROW; g++) begin : g_lane
        skew_rd_lane #(
            .LANE       (g),
            .ADDR_WIDTH (ADDR_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_lane (
            .issue   (issue_nxt),
            .t       (t_nxt),
            .n       (n_d),
            .base    (base_d),
            .aligned (aligned_d),
            .en      (lane_en[g]),
            .addr    (lane_addr[g])
        );
    end

    always_comb begin
        rd_en_d       = lane_en;
        rd_addr_d     = lane_addr;
        vld_pipe_d    = vld_pipe_q;
        vld_pipe_d[0] = rd_en_q;
        for (int k = RD_LAT - 1; k > 0; k--) vld_pipe_d[k] = vld_pipe_q[k-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            base_q     <= '0;
            n_q        <= '0;
            aligned_q  <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= '0;
            rd_addr_q  <= '1;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            base_q     <= base_d;
            n_q        <= n_d;
            aligned_q  <= aligned_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign data_valid = vld_pipe_q[RD_LAT-1];
endmodule

// File: tb/tb_skew_rd_sched.sv
// Bench for skew_rd_sched: directed plan steps plus random commands, every cycle
// checked against a cycle-number model of the command timeline.

module tb_skew_rd_sched;
    localparam int SR = 4;
    localparam int AW = 8;
    localparam int RW = 16;
    localparam int MR = 256;
    localparam int RL = 2;

    logic             clk = 1'b0;
    logic             rst, cmd_valid, cmd_ready, cmd_aligned, busy, done;
    logic [AW-1:0]    cmd_base;
    logic [RW-1:0]    cmd_num_row;
    logic [SR-1:0]    rd_en, data_valid;
    logic [SR*AW-1:0] rd_addr;

    skew_rd_sched #(
        .SYS_ROW (SR), .ADDR_WIDTH (AW), .ROW_WIDTH (RW), .MAX_ROW (MR), .RD_LAT (RL)
    ) dut (
        .clk (clk), .rst (rst), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_base (cmd_base), .cmd_num_row (cmd_num_row), .cmd_aligned (cmd_aligned),
        .rd_en (rd_en), .rd_addr (rd_addr), .data_valid (data_valid),
        .busy (busy), .done (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: m_k is the cycle number since acceptance (acceptance edge ends cycle 0).
    bit m_busy = 1'b0;
    bit m_al;
    int m_k, m_n, m_l, m_end, m_base;
    int beats[SR];
    int done_cyc, done_cnt;

    function automatic bit f_en(int lane, int k);
        int t;
        t = k - 1;
        if (!m_busy || t < 0 || t >= m_l) return 1'b0;
        if (m_al) return t < m_n;
        return (t >= lane) && (t < lane + m_n);
    endfunction

    function automatic int f_addr(int lane, int k);
        if (!f_en(lane, k)) return 255;
        return (m_base + (m_al ? k - 1 : k - 1 - lane)) & 255;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_busy = 1'b0;
        else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1'b1;
                m_k    = 1;
                m_base = int'(cmd_base);
                m_n    = (int'(cmd_num_row) > MR) ? MR : int'(cmd_num_row);
                m_al   = cmd_aligned;
                m_l    = (m_n == 0) ? 0 : (m_al ? m_n : m_n + SR - 1);
                m_end  = (m_n == 0) ? 1 : m_l + RL;
            end
        end else begin
            m_k++;
            if (m_k > m_end) m_busy = 1'b0;
        end
        #1;
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("done", done, m_busy && (m_k == m_end));
        for (int i = 0; i < SR; i++) begin
            chk($sformatf("rd_en[%0d]", i), rd_en[i], f_en(i, m_k));
            chk($sformatf("rd_addr[%0d]", i), rd_addr[i*AW +: AW], f_addr(i, m_k));
            chk($sformatf("data_valid[%0d]", i), data_valid[i], f_en(i, m_k - RL));
            beats[i] += int'(rd_en[i]);
        end
        if (done) begin
            done_cyc = m_k;
            done_cnt++;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (m_busy && b < 1000) begin
            step();
            b++;
        end
        chk("drain_bound", m_busy, 1'b0);
    endtask

    task automatic set_cmd(bit v, int base, int n, bit al);
        cmd_valid   = v;
        cmd_base    = AW'(base);
        cmd_num_row = RW'(n);
        cmd_aligned = al;
    endtask

    initial begin
        rst = 1'b1;
        set_cmd(0, 0, 0, 0);
        step();
        step();
        chk("reset_addr", rd_addr, {SR*AW{1'b1}});
        rst = 1'b0;
        step();

        // Basic skew, with a second command held on cmd_valid throughout.
        set_cmd(1, 'h10, 3, 0);
        step();
        chk("basic_lane0_c1", rd_addr[0 +: AW], 'h10);
        cmd_base = 8'h40;
        for (int c = 2; c <= 10; c++) begin
            step();
            if (c == 4) chk("basic_lane3_c4", rd_en[3], 1'b1);
            if (c == 8) chk("basic_done_c8", done, 1'b1);
            if (c == 9) chk("basic_ready_c9", cmd_ready, 1'b1);
        end
        chk("second_lane0_c10", rd_addr[0 +: AW], 'h40);
        cmd_valid = 1'b0;
        drain();

        // Aligned, wrapping address.
        set_cmd(1, 'hFE, 4, 1);
        step();
        cmd_valid = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            step();
            if (c == 3) chk("wrap_lane2_c3", rd_addr[2*AW +: AW], 'h00);
        end
        chk("wrap_done_c6", done, 1'b1);
        drain();

        // Clamp.
        for (int i = 0; i < SR; i++) beats[i] = 0;
        done_cyc = -1;
        set_cmd(1, 'h00, 300, 0);
        step();
        cmd_valid = 1'b0;
        drain();
        for (int i = 0; i < SR; i++) chk($sformatf("clamp_beats[%0d]", i), beats[i], 256);
        chk("clamp_done_cyc", done_cyc, 261);

        // N = 0.
        set_cmd(1, 'h33, 0, 0);
        step();
        cmd_valid = 1'b0;
        chk("n0_done_c1", done, 1'b1);
        chk("n0_no_rd", rd_en, '0);
        step();
        chk("n0_ready_c2", cmd_ready, 1'b1);

        // Reset in cycle 3 of a basic command.
        done_cnt = 0;
        set_cmd(1, 'h10, 3, 0);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ready_c4", cmd_ready, 1'b1);
        chk("rst_addr_c4", rd_addr, {SR*AW{1'b1}});
        for (int c = 0; c < 10; c++) step();
        chk("rst_no_done", done_cnt, 0);

        // Random commands; cmd_valid and fields churn while busy.
        for (int it = 0; it < 40; it++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 300) : $urandom_range(0, 12);
            set_cmd(1, $urandom_range(0, 255), n, $urandom_range(0, 1));
            step();
            while (m_busy) begin
                set_cmd($urandom_range(0, 1), $urandom_range(0, 255),
                        $urandom_range(0, 20), $urandom_range(0, 1));
                if ($urandom_range(0, 150) == 0) rst = 1'b1;
                step();
                rst = 1'b0;
            end
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/skew_rd_sched.md
# skew_rd_sched

Parametrised skewed-read scheduler that drives the per-row read ports of the accumulator/activation SRAM banks feeding the systolic array. It accepts one read command at a time over a valid/ready handshake. Each command carries a base address, a row count and a mode. In skew mode, lane i is delayed by i cycles; in aligned mode, all lanes read together. The block produces per-lane read enables and addresses, per-lane data-valid strobes delayed by the SRAM read latency, and a completion pulse.

## Interface
Parameters:
- SYS_ROW, 16: number of lanes (systolic rows); must be ≥ 2.
- ADDR_WIDTH, 8: SRAM address width per lane.
- ROW_WIDTH, 16: width of the command row-count field.
- MAX_ROW, 256: largest legal row count; larger requests are clamped.
- RD_LAT, 2: SRAM read latency in cycles; must be ≥ 1.
- CNT_WIDTH (localparam): $clog2(MAX_ROW+SYS_ROW)+1.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rst, input, 1: reset. One clock; reset is synchronous and active-high.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block is idle and will accept a command.
- cmd_base, input, ADDR_WIDTH: first row address.
- cmd_num_row, input, ROW_WIDTH: number of rows per lane.
- cmd_aligned, input, 1: 0 selects skew mode; 1 selects aligned mode.
- rd_en, output, SYS_ROW: per-lane SRAM read enable; bit i belongs to lane i.
- rd_addr, output, SYS_ROW*ADDR_WIDTH: per-lane address, flattened; lane i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- data_valid, output, SYS_ROW: rd_en delayed by RD_LAT cycles; marks SRAM output data valid.
- busy, output, 1: command in progress (equal to !cmd_ready).
- done, output, 1: single-cycle completion pulse.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - ISSUE: reads are being issued.
  - DRAIN: waiting for the latency pipeline to empty.
- Command acceptance:
  - A command is accepted on a clock edge where cmd_valid && cmd_ready.
  - At acceptance the block latches base, N = min(cmd_num_row, MAX_ROW) and the mode.
  - cmd_valid is ignored outside IDLE. Inputs are don't-care when not accepted.
- Issue length L:
  - Skew mode: L = N + SYS_ROW − 1.
  - Aligned mode: L = N.
- Issue counter t runs 0..L−1 in ISSUE. It is CNT_WIDTH wide and never overflows.
- Lane activity in skew mode: lane i is active when i ≤ t < i+N, with address base + (t − i).
- Lane activity in aligned mode: all lanes are active for t < N, with address base + t.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps, no error).
- An inactive lane drives rd_en=0 and rd_addr = all-ones.
- rd_en and rd_addr are registered outputs.
- data_valid is a RD_LAT-deep shift register of rd_en. It is independent of FSM state and keeps shifting in DRAIN.
- Transitions:
  - IDLE→ISSUE on acceptance with N>0.
  - ISSUE→DRAIN after the edge that issues t=L−1.
  - DRAIN→IDLE after the final data_valid beat.
- N=0: the command is accepted, no reads are issued, and done pulses one cycle after acceptance. The block goes straight back to IDLE.
- Reset:
  - Outputs go to cmd_ready=1, busy=0, done=0, rd_en=0, data_valid=0, rd_addr all-ones.
  - State goes to IDLE and counters clear.
  - Reset asserted mid-command discards the command; no done pulse is produced for it.

## Timing
- Cycle numbering: the acceptance edge ends cycle 0.
- rd_en is first visible in cycle 1, for issue index t=0. Issue index t appears in cycle t+1.
- rd_en is active over cycles 1..L. data_valid is active over cycles 1+RD_LAT..L+RD_LAT.
- done is high in cycle L+RD_LAT, coinciding with the last data_valid beat (lane SYS_ROW−1 in skew mode).
- cmd_ready is high again in cycle L+RD_LAT+1. The next command can be accepted at the end of that cycle.
- Minimum command-to-command spacing is L+RD_LAT+1 cycles.
- busy = !cmd_ready in every cycle.

## Test plan
- Skew, basic (SYS_ROW=4, RD_LAT=2, base=0x10, N=3):
  - Lane 0: rd_en in cycles 1–3, addresses 0x10, 0x11, 0x12.
  - Lane 3: rd_en in cycles 4–6, addresses 0x10..0x12.
  - data_valid lane 3 in cycles 6–8; done in cycle 8; cmd_ready in cycle 9.
- Wrap and aligned (base=0xFE, N=4, aligned):
  - All lanes: rd_en in cycles 1–4, addresses 0xFE, 0xFF, 0x00, 0x01.
  - done in cycle 6.
- Clamp (MAX_ROW=256, cmd_num_row=300, skew, SYS_ROW=4):
  - Exactly 256 rd_en beats per lane.
  - done in cycle 259+RD_LAT = 261.
- N=0:
  - No rd_en at any time; done in cycle 1; cmd_ready in cycle 2.
- Busy rejection:
  - cmd_valid held high with new base=0x40 throughout the first test.
  - Only the first command executes; the second is accepted in cycle 9, and its lane 0 reads 0x40 from cycle 10.
- Reset mid-op:
  - rst asserted in cycle 3 of the basic test.
  - From cycle 4: rd_en=0, data_valid=0, rd_addr all-ones, cmd_ready=1.
  - done never pulses.
